// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter onto one single-port memory; MEM_ARBITER_RR_EN selects round-robin
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ireq,
  input  logic [ADDR_W-1:0] i_iaddr,
  output logic              o_iack,
  output logic [DATA_W-1:0] o_irdata,
  input  logic              i_dreq,
  input  logic              i_dwen,
  input  logic [ADDR_W-1:0] i_daddr,
  input  logic [DATA_W-1:0] i_dwdata,
  output logic              o_dack,
  output logic [DATA_W-1:0] o_drdata,
  output logic              o_mem_cen,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic       grant_d;   // current access belongs to the data port
  logic       lat_wen;   // current access is a write
  logic       win_d;     // data port wins the request sampled this cycle

`ifdef MEM_ARBITER_RR_EN
  logic       last_i;    // last grant went to the instruction port

  // Round-robin: on a tie the port not granted last wins
  always_comb begin
    win_d = i_dreq && (!i_ireq || last_i);
  end
`else
  // Fixed priority: data port wins every tie
  always_comb begin
    win_d = i_dreq;
  end
`endif

  // Access sequencer: IDLE samples requests, ISSUE drives the memory, WAIT captures data, DONE acks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      grant_d     <= 1'b0;
      lat_wen     <= 1'b0;
      o_iack      <= 1'b0;
      o_irdata    <= '0;
      o_dack      <= 1'b0;
      o_drdata    <= '0;
      o_mem_cen   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_ireq || i_dreq) begin
            state      <= S_ISSUE;
            o_busy     <= 1'b1;
            grant_d    <= win_d;
            lat_wen    <= win_d && i_dwen;
            o_mem_cen  <= 1'b1;
            o_mem_wen  <= win_d && i_dwen;
            o_mem_addr <= win_d ? i_daddr : i_iaddr;
            // Write data only changes for data grants; it otherwise holds
            if (win_d) begin
              o_mem_wdata <= i_dwdata;
            end
          end
        end
        S_ISSUE: begin
          state     <= S_WAIT;
          o_mem_cen <= 1'b0;
          o_mem_wen <= 1'b0;
        end
        S_WAIT: begin
          state <= S_DONE;
          if (grant_d) begin
            o_drdata <= lat_wen ? '0 : i_mem_rdata;
            o_dack   <= 1'b1;
          end else begin
            o_irdata <= i_mem_rdata;
            o_iack   <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
          o_iack <= 1'b0;
          o_dack <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Priority pointer follows every grant; reset makes the first tie go to data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_i <= 1'b1;
    end else if (state == S_IDLE && (i_ireq || i_dreq)) begin
      last_i <= !win_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iack;
  logic [31:0] irdata;
  logic        dreq;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        dack;
  logic [31:0] drdata;
  logic        mem_cen;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:255];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ireq(ireq), .i_iaddr(iaddr), .o_iack(iack), .o_irdata(irdata),
    .i_dreq(dreq), .i_dwen(dwen), .i_daddr(daddr), .i_dwdata(dwdata),
    .o_dack(dack), .o_drdata(drdata),
    .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port memory model: read data appears the cycle after the enable
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
      else         mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwen = 1'b0; daddr = '0; dwdata = '0;
    step; step;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0h exp 0", busy); end
    vectors++; if ({iack, dack, mem_cen, mem_wen} !== 4'b0) begin miscompares++; $display("FAIL reset_strobes got %b exp 0000", {iack, dack, mem_cen, mem_wen}); end
    vectors++; if ({irdata, drdata, mem_addr, mem_wdata} !== 128'b0) begin miscompares++; $display("FAIL reset_data got %h exp 0", {irdata, drdata, mem_addr, mem_wdata}); end
  endtask

  task automatic test_inst_read;
    // Request raised together with reset release: the first edge may accept it
    rst = 1'b0; ireq = 1'b1; iaddr = 32'h10;
    step;
    vectors++; if (mem_cen !== 1'b1 || mem_wen !== 1'b0) begin miscompares++; $display("FAIL iread_issue got cen=%0h wen=%0h exp cen=1 wen=0", mem_cen, mem_wen); end
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL iread_addr got %h exp 00000010", mem_addr); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL iread_busy got %0h exp 1", busy); end
    step;
    vectors++; if (mem_cen !== 1'b0 || iack !== 1'b0) begin miscompares++; $display("FAIL iread_wait got cen=%0h ack=%0h exp 0 0", mem_cen, iack); end
    step;
    vectors++; if (iack !== 1'b1 || dack !== 1'b0) begin miscompares++; $display("FAIL iread_ack got iack=%0h dack=%0h exp 1 0", iack, dack); end
    vectors++; if (irdata !== 32'h8C01_0004) begin miscompares++; $display("FAIL iread_data got %h exp 8c010004", irdata); end
    ireq = 1'b0;
    step;
    vectors++; if (iack !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL iread_idle got iack=%0h busy=%0h exp 0 0", iack, busy); end
  endtask

  task automatic test_data_write;
    dreq = 1'b1; dwen = 1'b1; daddr = 32'h40; dwdata = 32'hDEAD_BEEF;
    step;
    vectors++; if (mem_cen !== 1'b1 || mem_wen !== 1'b1) begin miscompares++; $display("FAIL dwr_issue got cen=%0h wen=%0h exp 1 1", mem_cen, mem_wen); end
    vectors++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL dwr_bus got %h/%h exp 00000040/deadbeef", mem_addr, mem_wdata); end
    step;
    vectors++; if (mem_wen !== 1'b0 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL dwr_hold got wen=%0h %h/%h exp 0 00000040/deadbeef", mem_wen, mem_addr, mem_wdata); end
    step;
    vectors++; if (dack !== 1'b1 || drdata !== 32'h0) begin miscompares++; $display("FAIL dwr_ack got dack=%0h drdata=%h exp 1 0", dack, drdata); end
    vectors++; if (irdata !== 32'h8C01_0004) begin miscompares++; $display("FAIL dwr_irdata_hold got %h exp 8c010004", irdata); end
    dreq = 1'b0;
    step;
    // Read back the written word through the data port
    dreq = 1'b1; dwen = 1'b0;
    step;
    vectors++; if (mem_wen !== 1'b0 || mem_cen !== 1'b1) begin miscompares++; $display("FAIL drd_issue got cen=%0h wen=%0h exp 1 0", mem_cen, mem_wen); end
    step; step;
    vectors++; if (dack !== 1'b1 || drdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL drd_ack got dack=%0h drdata=%h exp 1 deadbeef", dack, drdata); end
    dreq = 1'b0;
    step;
  endtask

  task automatic test_tie;
    logic [3:0] exp_d;
    int n;
`ifdef MEM_ARBITER_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    rst = 1'b1;
    step;
    rst = 1'b0; ireq = 1'b1; iaddr = 32'h10; dreq = 1'b1; dwen = 1'b0; daddr = 32'h40;
    for (int g = 0; g < 5; g++) begin
      if (g == 4) dreq = 1'b0;
      step;
      n = 1;
      while (!(iack || dack) && n < 8) begin
        step;
        n++;
      end
      vectors++;
      if (n >= 8) begin
        miscompares++; $display("FAIL tie_timeout grant %0d got no ack exp ack within 8 cycles", g);
      end else if (g < 4 && dack !== exp_d[g]) begin
        miscompares++; $display("FAIL tie_order grant %0d got dack=%0h exp %0h", g, dack, exp_d[g]);
      end else if (g == 4 && iack !== 1'b1) begin
        miscompares++; $display("FAIL tie_release got iack=%0h exp 1", iack);
      end else if ((dack && drdata !== 32'hDEAD_BEEF) || (iack && irdata !== 32'h8C01_0004)) begin
        miscompares++; $display("FAIL tie_data grant %0d got %h/%h exp 8c010004/deadbeef", g, irdata, drdata);
      end
    end
    ireq = 1'b0; dreq = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    ireq = 1'b1; iaddr = 32'h10;
    step; step; step;
    vectors++; if (iack !== 1'b1 || irdata !== 32'h8C01_0004) begin miscompares++; $display("FAIL b2b_first got iack=%0h %h exp 1 8c010004", iack, irdata); end
    iaddr = 32'h14;
    step;
    vectors++; if (busy !== 1'b0 || mem_cen !== 1'b0 || iack !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got busy=%0h cen=%0h iack=%0h exp 0 0 0", busy, mem_cen, iack); end
    step;
    vectors++; if (mem_cen !== 1'b1 || mem_addr !== 32'h14 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_issue got cen=%0h addr=%h busy=%0h exp 1 00000014 1", mem_cen, mem_addr, busy); end
    step;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_wait_busy got %0h exp 1", busy); end
    step;
    vectors++; if (iack !== 1'b1 || irdata !== 32'h1234_5678) begin miscompares++; $display("FAIL b2b_second got iack=%0h %h exp 1 12345678", iack, irdata); end
    ireq = 1'b0;
    step;
  endtask

  task automatic test_reset_in_wait;
    ireq = 1'b1; iaddr = 32'h10;
    step; step;
    vectors++; if (busy !== 1'b1 || mem_cen !== 1'b0) begin miscompares++; $display("FAIL rstw_in_wait got busy=%0h cen=%0h exp 1 0", busy, mem_cen); end
    rst = 1'b1; ireq = 1'b0;
    step;
    vectors++; if ({busy, iack, dack, mem_cen, mem_wen} !== 5'b0) begin miscompares++; $display("FAIL rstw_strobes got %b exp 00000", {busy, iack, dack, mem_cen, mem_wen}); end
    vectors++; if ({irdata, drdata, mem_addr, mem_wdata} !== 128'b0) begin miscompares++; $display("FAIL rstw_data got %h exp 0", {irdata, drdata, mem_addr, mem_wdata}); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      vectors++; if (iack !== 1'b0 || dack !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstw_no_ack cycle %0d got iack=%0h dack=%0h busy=%0h exp 0 0 0", i, iack, dack, busy); end
    end
  endtask

  task automatic test_drop_in_issue;
    dreq = 1'b1; dwen = 1'b0; daddr = 32'h40;
    step;
    vectors++; if (mem_cen !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL drop_issue got cen=%0h addr=%h exp 1 00000040", mem_cen, mem_addr); end
    dreq = 1'b0;
    step; step;
    vectors++; if (dack !== 1'b1 || drdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL drop_ack got dack=%0h %h exp 1 deadbeef", dack, drdata); end
    for (int i = 0; i < 3; i++) begin
      step;
      vectors++; if (mem_cen !== 1'b0 || busy !== 1'b0 || dack !== 1'b0) begin miscompares++; $display("FAIL drop_no_regrant cycle %0d got cen=%0h busy=%0h dack=%0h exp 0 0 0", i, mem_cen, busy, dack); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h8C01_0004;
    mem[5] = 32'h1234_5678;
    mem_rdata = 32'h0;
    test_reset;
    test_inst_read;
    test_data_write;
    test_tie;
    test_back_to_back;
    test_reset_in_wait;
    test_drop_in_issue;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_ireq  input  1  instruction-port read request; held high until o_iack.
REQ-006 i_iaddr  input  ADDR_W  instruction-port address; stable while i_ireq high.
REQ-007 o_iack  output  1  one-cycle pulse: instruction read complete, o_irdata valid.
REQ-008 o_irdata  output  DATA_W  instruction read data.
REQ-009 i_dreq  input  1  data-port request; held high until o_dack.
REQ-010 i_dwen  input  1  data-port direction: 1 write, 0 read.
REQ-011 i_daddr  input  ADDR_W  data-port address.
REQ-012 i_dwdata  input  DATA_W  data-port write data.
REQ-013 o_dack  output  1  one-cycle pulse: data access complete.
REQ-014 o_drdata  output  DATA_W  data read data.
REQ-015 o_mem_cen  output  1  shared single-port memory enable.
REQ-016 o_mem_wen  output  1  shared memory write enable.
REQ-017 o_mem_addr  output  ADDR_W  shared memory address.
REQ-018 o_mem_wdata  output  DATA_W  shared memory write data.
REQ-019 i_mem_rdata  input  DATA_W  memory read data, valid one cycle after o_mem_cen.
REQ-020 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-022 IDLE: no request -> stay; any request -> latch winner, address, wen, wdata; go ISSUE.
REQ-023 ISSUE: o_mem_cen=1 for exactly this cycle, o_mem_addr/o_mem_wen/o_mem_wdata from latched values; go WAIT.
REQ-024 WAIT: capture i_mem_rdata into winner's rdata register; go DONE.
REQ-025 DONE: winner's ack=1 for exactly this cycle; go IDLE; requests are not sampled in DONE.
REQ-026 Latency: request seen in IDLE at cycle T -> ack at T+3; one access per 4 cycles maximum.
REQ-027 Instruction port always reads (o_mem_wen=0); o_mem_wen=i_dwen only for data grants.
REQ-028 Data write: o_drdata driven 0 at its ack; o_irdata/o_drdata otherwise hold last value.
REQ-029 Loser's request stays pending and is served at the next IDLE.
REQ-030 Request dropped before ack: in-flight access still completes and acks; no abort.
REQ-031 Requester must deassert req in the cycle after ack or keep it high for a new access.
REQ-032 Outside ISSUE: o_mem_cen=0, o_mem_wen=0; addr/wdata hold last values.
REQ-033 Addresses and data pass unmodified; no alignment check or translation.

Reset
REQ-034 On i_rst high at a rising edge: state=IDLE, all outputs 0, latched address/data 0, priority pointer = "last granted instruction".
REQ-035 Reset mid-operation discards in-flight access; no ack issued for it.
REQ-036 First edge after i_rst low may accept a request.

Configuration
REQ-037 Macro MEM_ARBITER_RR_EN defined: round-robin; on simultaneous requests grant the port not granted last; pointer updates at every grant.
REQ-038 Macro undefined: fixed priority, data port always wins ties; pointer logic absent.
REQ-039 Both modes: single requester always granted; after reset first tie goes to data port.

Verification
REQ-040 Reset then i_ireq=1, i_iaddr=0x10, mem returns 0x8C01_0004 -> o_mem_cen pulse with addr 0x10 at T+1, o_iack=1, o_irdata=0x8C01_0004 at T+3.
REQ-041 i_dreq=1, i_dwen=1, i_daddr=0x40, i_dwdata=0xDEAD_BEEF -> o_mem_wen=1 at T+1 with those values, o_dack at T+3, o_drdata=0.
REQ-042 Both requests held continuously, 4 grants -> RR_EN: D,I,D,I; without macro: D,D,D,D, instruction starved until i_dreq drops.
REQ-043 Back-to-back reads, i_ireq held after ack with new addr 0x14 -> second ISSUE exactly 2 cycles after first ack, o_busy low only in the IDLE cycle.
REQ-044 i_rst asserted in WAIT -> next cycle o_busy=0, no o_iack/o_dack pulse, all outputs 0.
REQ-045 i_dreq dropped during ISSUE -> o_dack still pulses at T+3; no new grant follows.
